// File: rtl/fsm_sequencer.sv
// Run controller for a small serial-input FSM: clears it, shifts a pattern onto x
// MSB first, and counts the cycles in which y equals MATCH (saturating).
module fsm_sequencer #(
    parameter int          LEN   = 8,
    parameter int          CW    = 4,
    parameter logic [1:0]  MATCH = 2'b11
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           start_i,
    input  logic           abort_i,
    input  logic [LEN-1:0] pattern_i,
    input  logic [1:0]     y_i,
    output logic           x_o,
    output logic           fsm_rst_o,
    output logic           busy_o,
    output logic           done_o,
    output logic [CW-1:0]  hits_o
);

    // state | meaning
    // IDLE  | controlled FSM held in reset, waiting for start
    // CLEAR | one clear cycle with the FSM still in reset
    // RUN   | FSM released, one pattern bit per clock on x
    // DONE  | single-cycle completion pulse
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int CNTW = $clog2(LEN + 1);

    state_t              state_q, state_d;
    logic [LEN-1:0]      shreg_q, shreg_d;
    logic [CNTW-1:0]     cnt_q,   cnt_d;
    logic [CW-1:0]       hits_q,  hits_d;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            hits_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            hits_q  <= hits_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        hits_d  = hits_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    shreg_d = pattern_i;
                    cnt_d   = '0;
                    hits_d  = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = abort_i ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                // An abort edge discards that bit entirely: no shift, no hit.
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    shreg_d = {shreg_q[LEN-2:0], 1'b0};
                    cnt_d   = cnt_q + CNTW'(1);
                    if ((y_i == MATCH) && (hits_q != {CW{1'b1}})) begin
                        hits_d = hits_q + CW'(1);
                    end
                    if (cnt_q == CNTW'(LEN - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign x_o       = (state_q == ST_RUN) & shreg_q[LEN-1];
    assign fsm_rst_o = (state_q != ST_RUN);
    assign busy_o    = (state_q == ST_CLEAR) || (state_q == ST_RUN);
    assign done_o    = (state_q == ST_DONE);
    assign hits_o    = hits_q;

endmodule

// File: tb/tb_fsm_sequencer.sv
// Directed and randomized runs of fsm_sequencer checked against a per-run model;
// a second instance with a 2-bit hit counter checks saturation.
module tb_fsm_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [1:0] y;
    logic       x, fsm_rst, busy, done;
    logic [3:0] hits;
    logic       x_s, fsm_rst_s, busy_s, done_s;
    logic [1:0] hits_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fsm_sequencer #(.LEN(8), .CW(4), .MATCH(2'b11)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .pattern_i(pattern), .y_i(y),
        .x_o(x), .fsm_rst_o(fsm_rst), .busy_o(busy), .done_o(done), .hits_o(hits)
    );

    fsm_sequencer #(.LEN(8), .CW(2), .MATCH(2'b11)) dut_sat (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .pattern_i(pattern), .y_i(y),
        .x_o(x_s), .fsm_rst_o(fsm_rst_s), .busy_o(busy_s), .done_o(done_s), .hits_o(hits_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int sat3(input int h);
        return (h > 3) ? 3 : h;
    endfunction

    // ymode: 0 y=11, 1 y={x,x}, 2 random, 3 y=00
    // abort_at: -1 abort in CLEAR, 0..7 abort in that RUN bit, other = none
    task automatic run(input logic [7:0] p, input int ymode, input int abort_at,
                       input int reset_at, input int inj_at, input bit sa, input bit hold);
        int exp_hits = 0;
        int rst_low  = 0;
        logic       b;
        logic [1:0] yv;
        start = 1'b1; pattern = p; abort = sa;
        step();
        start = 1'b0; abort = 1'b0;
        chk("clr_busy", busy, 1);
        chk("clr_fsm_rst", fsm_rst, 1);
        chk("clr_x", x, 0);
        chk("clr_hits", hits, 0);
        if (abort_at == -1) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("abclr_busy", busy, 0);
            chk("abclr_fsm_rst", fsm_rst, 1);
            step();
            chk("abclr_done", done, 0);
            chk("abclr_hits", hits, 0);
            return;
        end
        step();
        for (int i = 0; i < 8; i++) begin
            b = p[7-i];
            chk("run_x", x, b);
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            if (fsm_rst == 1'b0) rst_low++;
            case (ymode)
                0:       yv = 2'b11;
                1:       yv = {b, b};
                2:       yv = 2'($urandom_range(0, 3));
                default: yv = 2'b00;
            endcase
            y = yv;
            if (inj_at == i) begin
                start = 1'b1; pattern = 8'hFF;
            end
            if (reset_at == i) begin
                reset = 1'b0;
                step();
                reset = 1'b1; y = 2'b00;
                chk("rst_x", x, 0);
                chk("rst_fsm_rst", fsm_rst, 1);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_hits", hits, 0);
                chk("rst_hits_sat", hits_s, 0);
                return;
            end
            if (abort_at == i) begin
                abort = 1'b1;
                step();
                abort = 1'b0; y = 2'b00;
                chk("ab_busy", busy, 0);
                chk("ab_fsm_rst", fsm_rst, 1);
                chk("ab_done", done, 0);
                chk("ab_hits", hits, exp_hits);
                chk("ab_hits_sat", hits_s, sat3(exp_hits));
                step();
                chk("ab_no_done", done, 0);
                chk("ab_hits_hold", hits, exp_hits);
                return;
            end
            if (yv == 2'b11) exp_hits++;
            step();
            start = 1'b0; pattern = p;
        end
        y = 2'b00;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_fsm_rst", fsm_rst, 1);
        chk("done_x", x, 0);
        chk("rst_low_cycles", rst_low, 8);
        chk("hits", hits, exp_hits);
        chk("hits_sat", hits_s, sat3(exp_hits));
        start = hold;
        step();
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("hits_hold", hits, exp_hits);
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; abort = 1'b1; pattern = 8'hB3; y = 2'b11;
        step();
        step();
        chk("reset_x", x, 0);
        chk("reset_fsm_rst", fsm_rst, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hits", hits, 0);
        start = 1'b0; abort = 1'b0; y = 2'b00; reset = 1'b1;
        step();
        chk("idle_busy", busy, 0);
        chk("idle_fsm_rst", fsm_rst, 1);

        run(8'hB3, 0, 99, 99, 99, 1'b0, 1'b0);  // hits 8, sat 3
        run(8'hB3, 1, 99, 99, 99, 1'b0, 1'b0);  // hits 5
        run(8'h00, 1, 99, 99, 99, 1'b0, 1'b0);  // hits 0, done still pulses
        run(8'hB3, 0, 99, 99, 3,  1'b0, 1'b0);  // start while busy ignored
        run(8'hB3, 0, 3,  99, 99, 1'b0, 1'b0);  // abort after 3 bits
        run(8'hB3, 0, 99, 3,  99, 1'b0, 1'b0);  // reset mid-run
        run(8'h5A, 0, -1, 99, 99, 1'b0, 1'b0);  // abort in CLEAR
        run(8'hC3, 0, 7,  99, 99, 1'b0, 1'b0);  // abort on final bit: 7 hits
        run(8'h6D, 1, 99, 99, 99, 1'b1, 1'b0);  // start+abort in IDLE
        run(8'h81, 1, 99, 99, 99, 1'b0, 1'b1);  // start held through DONE
        run(8'h7E, 1, 99, 99, 99, 1'b0, 1'b0);  // back-to-back follow-up

        for (int k = 0; k < 8; k++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 99;
            run(8'($urandom), 2, ab, 99, 99, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
